wshb_mire_writer: RTL and testbench
===================================

Name: wshb_mire_writer

Overview:
Wishbone master that fills the SDRAM framebuffer with a grid test pattern ("mire") for the VGA reader to display. It sits upstream of the VGA scan-out stage on the same SDRAM Wishbone bus, on the SDRAM/Wishbone clock domain. It writes pixels in raster order using the same address mapping the VGA reader uses. It releases cyc after every burst so the VGA reader can win bus arbitration.

Parameters:
HDISP, 800, active pixels per line
VDISP, 480, active lines per frame
BASE_ADDR, 0, byte address of pixel (0,0)
BURST_LEN, 64, writes per bus ownership before cyc is released
PAUSE_CYCLES, 16, idle cycles with cyc=0 between bursts
GRID_LOG2, 4, grid pitch = 2**GRID_LOG2 pixels

Ports:
clk  in  1  Wishbone/SDRAM clock; all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
enable  in  1  level; 1 = keep writing frames, 0 = stop at next burst boundary
frame_done  out  1  one-cycle pulse on the ack of the last pixel of a frame
wshb_cyc  out  1  Wishbone cycle
wshb_stb  out  1  Wishbone strobe
wshb_we  out  1  write enable
wshb_adr  out  32  byte address
wshb_dat_ms  out  32  write data
wshb_sel  out  4  byte select, constant 4'hF
wshb_cti  out  3  constant 0 (classic cycle)
wshb_bte  out  2  constant 0
wshb_ack  in  1  slave acknowledge

Behaviour:
- Reset (rst_n=0 sampled at an edge):
  - Outputs: cyc=stb=we=0, adr=BASE_ADDR, dat_ms=0, frame_done=0.
  - Internal: x=y=0, burst_cnt=0, pause_cnt=0, state=IDLE.
  - Reset mid-transfer drops cyc/stb at that edge with no completion; the next frame restarts at (0,0).
- Counters:
  - x is $clog2(HDISP) bits; y is $clog2(VDISP) bits.
  - x wraps HDISP-1 -> 0 and increments y. y wraps VDISP-1 -> 0.
- Address: wshb_adr = BASE_ADDR + (y*HDISP + x)*4, computed at 32 bits, combinational from x,y.
- Data:
  - 32'h00FFFFFF when x[GRID_LOG2-1:0]==0 or y[GRID_LOG2-1:0]==0; else 32'h00000000.
  - Format is {8'h00,R,G,B}. Combinational from x,y.
- Bus outputs by state:
  - cyc=stb=we=1 only in WRITE; all 0 in IDLE and PAUSE.
  - adr/dat_ms are always driven from x,y, and are stable while stb=1 and ack=0.
- FSM states IDLE, WRITE, PAUSE:
  - IDLE: enable=1 -> WRITE at the next edge. Otherwise stay. x,y are retained; no restart.
  - WRITE: stb is held until ack. On an edge with ack=1:
    - Advance x/y and increment burst_cnt.
    - Last pixel (x=HDISP-1, y=VDISP-1): frame_done=1 for that cycle, wrap to (0,0), burst_cnt=0, go to PAUSE. This takes priority over the burst boundary.
    - Else if burst_cnt==BURST_LEN-1: burst_cnt=0, go to PAUSE.
    - Else stay in WRITE. With ack held high, one write completes per cycle, back-to-back.
  - PAUSE: count PAUSE_CYCLES cycles (pause_cnt 0..PAUSE_CYCLES-1). At the end, go to WRITE if enable=1, else IDLE.
  - PAUSE_CYCLES=0 is illegal.
- enable=0 during WRITE:
  - The burst continues to its boundary (or frame end); it is not aborted mid-transfer.
  - Then PAUSE, then IDLE.
- No ack is ever issued without stb; an ack while stb=0 is ignored.
- frame_done is registered, asserted exactly one cycle, and never asserted outside WRITE->PAUSE transitions.
- No timeout: the block waits indefinitely for ack.

Test Plan:
- Reset, config HDISP=8 VDISP=4 BURST_LEN=4 PAUSE_CYCLES=2, enable=1, ack tied high -> bursts of 4 writes at adr 0,4,8,12, then cyc=0 for 2 cycles, then adr 16..28; frame_done pulses once after 32 acks; next write is at adr 0.
- Pattern check, GRID_LOG2=2, HDISP=8 -> line 0 all 00FFFFFF; line 1 data FFFFFF at x=0,4, 0 elsewhere.
- Random ack delays 0-5 cycles -> adr/dat_ms stable while stb=1 and ack=0; exactly 32 distinct addresses per frame, no duplicates or skips.
- enable dropped after the 2nd ack of a burst -> 2 more writes complete, PAUSE, then IDLE with cyc=0. Re-enable -> resumes at the next address (adr 16 for the first burst case).
- rst_n low for one edge mid-WRITE with ack=0 -> cyc/stb=0 next cycle, frame_done=0; after release with enable=1 the writes restart at adr BASE_ADDR.
- BASE_ADDR=32'h1000, full default size with ack high -> last write at adr 0x1000+(800*480-1)*4, frame_done on that ack.

Source files
------------

// File: rtl/wshb_mire_writer.sv
// wshb_mire_writer: Wishbone master that paints a grid test pattern ("mire")
// into the SDRAM framebuffer in raster order. It uses the same pixel address
// mapping as the VGA reader. It releases cyc after every burst so the reader
// can win arbitration on the shared bus.
//
// Ports:
//   clk          Wishbone/SDRAM clock, rising edge
//   rst_n        synchronous active-low reset
//   enable       level; 1 = keep writing frames, 0 = stop at next burst boundary
//   frame_done   one-cycle pulse following the ack of a frame's last pixel
//   wshb_*       Wishbone classic master interface (write-only)
module wshb_mire_writer #(
  parameter int unsigned HDISP        = 800,
  parameter int unsigned VDISP        = 480,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int unsigned BURST_LEN    = 64,
  parameter int unsigned PAUSE_CYCLES = 16,
  parameter int unsigned GRID_LOG2    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        frame_done,
  output logic        wshb_cyc,
  output logic        wshb_stb,
  output logic        wshb_we,
  output logic [31:0] wshb_adr,
  output logic [31:0] wshb_dat_ms,
  output logic [3:0]  wshb_sel,
  output logic [2:0]  wshb_cti,
  output logic [1:0]  wshb_bte,
  input  logic        wshb_ack
);

  localparam int unsigned XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int unsigned YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned PW = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;

  // Low GRID_LOG2 bits of a coordinate; zero there means a grid line.
  localparam logic [31:0] GRID_MASK = 32'((64'd1 << GRID_LOG2) - 64'd1);
  localparam logic [31:0] WHITE     = 32'h00FF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [BW-1:0] burst_cnt;
  logic [PW-1:0] pause_cnt;

  logic        last_x, last_y, last_pixel, burst_end, pause_end, xfer;
  logic        on_grid;
  logic [31:0] pix_idx;

  assign last_x     = (x == XW'(HDISP - 1));
  assign last_y     = (y == YW'(VDISP - 1));
  assign last_pixel = last_x && last_y;
  assign burst_end  = (burst_cnt == BW'(BURST_LEN - 1));
  assign pause_end  = (pause_cnt == PW'(PAUSE_CYCLES - 1));
  // An ack only counts while we are actually strobing.
  assign xfer       = (state == WRITE) && wshb_ack;

  // Bus control is a pure decode of the state register.
  assign wshb_cyc = (state == WRITE);
  assign wshb_stb = (state == WRITE);
  assign wshb_we  = (state == WRITE);
  assign wshb_sel = 4'hF;
  assign wshb_cti = 3'd0;
  assign wshb_bte = 2'd0;

  // Raster address: BASE_ADDR + (y*HDISP + x)*4, all at 32 bits.
  assign pix_idx  = 32'(y) * 32'(HDISP) + 32'(x);
  assign wshb_adr = BASE_ADDR + {pix_idx[29:0], 2'b00};

  // Grid pattern; data is parked at zero whenever no write is in flight so the
  // bus reads zero out of reset and between bursts.
  assign on_grid     = ((32'(x) & GRID_MASK) == 32'd0) || ((32'(y) & GRID_MASK) == 32'd0);
  assign wshb_dat_ms = ((state == WRITE) && on_grid) ? WHITE : 32'h0;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; frame end and burst end both hand the bus back via PAUSE.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (enable) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (xfer && (last_pixel || burst_end)) begin
          state_next = PAUSE;
        end
      end
      PAUSE: begin
        if (pause_end) begin
          state_next = enable ? WRITE : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pixel position, burst length and pause counters plus the frame pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x          <= '0;
      y          <= '0;
      burst_cnt  <= '0;
      pause_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (xfer) begin
        frame_done <= last_pixel;
        if (last_x) begin
          x <= '0;
          y <= last_y ? '0 : y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
        burst_cnt <= (last_pixel || burst_end) ? '0 : burst_cnt + BW'(1);
      end
      // Counts only while pausing; cleared on exit so every pause is full length.
      if ((state == PAUSE) && !pause_end) begin
        pause_cnt <= pause_cnt + PW'(1);
      end else begin
        pause_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wshb_mire_writer.sv
// Directed bench for wshb_mire_writer: a small 8x4 instance exercises burst
// and pause timing, grid data, enable drop/resume, slow acks and reset; a
// 20x10 instance at BASE_ADDR 0x1000 checks a full frame with 64-write bursts.
module tb_wshb_mire_writer;

  logic        clk;
  logic        rst_n;

  logic        en_a, ack_a, fd_a, cyc_a, stb_a, we_a;
  logic [31:0] adr_a, dat_a;
  logic [3:0]  sel_a;
  logic [2:0]  cti_a;
  logic [1:0]  bte_a;

  logic        en_b, ack_b, fd_b, cyc_b, stb_b, we_b;
  logic [31:0] adr_b, dat_b;
  logic [3:0]  sel_b;
  logic [2:0]  cti_b;
  logic [1:0]  bte_b;

  int vectors;
  int miscompares;

  wshb_mire_writer #(
    .HDISP(8), .VDISP(4), .BASE_ADDR(32'h0), .BURST_LEN(4),
    .PAUSE_CYCLES(2), .GRID_LOG2(2)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .frame_done(fd_a),
    .wshb_cyc(cyc_a), .wshb_stb(stb_a), .wshb_we(we_a), .wshb_adr(adr_a),
    .wshb_dat_ms(dat_a), .wshb_sel(sel_a), .wshb_cti(cti_a), .wshb_bte(bte_a),
    .wshb_ack(ack_a)
  );

  wshb_mire_writer #(
    .HDISP(20), .VDISP(10), .BASE_ADDR(32'h1000), .BURST_LEN(64),
    .PAUSE_CYCLES(16), .GRID_LOG2(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .frame_done(fd_b),
    .wshb_cyc(cyc_b), .wshb_stb(stb_b), .wshb_we(we_b), .wshb_adr(adr_b),
    .wshb_dat_ms(dat_b), .wshb_sel(sel_b), .wshb_cti(cti_b), .wshb_bte(bte_b),
    .wshb_ack(ack_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected pixel colour for the 8-wide, pitch-4 instance.
  function automatic logic [31:0] exp_dat_a(input int p);
    int px, py;
    px = p % 8;
    py = p / 8;
    return ((px % 4) == 0 || (py % 4) == 0) ? 32'h00FF_FFFF : 32'h0;
  endfunction

  function automatic logic [31:0] exp_dat_b(input int p);
    int px, py;
    px = p % 20;
    py = p / 20;
    return ((px % 16) == 0 || (py % 16) == 0) ? 32'h00FF_FFFF : 32'h0;
  endfunction

  // Bounded wait for the next strobe of instance A; a timeout fails the check.
  task automatic wait_stb_a();
    int n;
    n = 0;
    while (stb_a !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("stb_wait_a", 32'(stb_a), 32'd1);
  endtask

  initial begin
    int  cnt_b;
    bit  done_b;
    logic [31:0] last_b;

    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    en_a  = 1'b0;
    ack_a = 1'b0;
    en_b  = 1'b0;
    ack_b = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state.
    chk("rst_cyc", 32'(cyc_a), 32'd0);
    chk("rst_stb", 32'(stb_a), 32'd0);
    chk("rst_we", 32'(we_a), 32'd0);
    chk("rst_adr", adr_a, 32'h0);
    chk("rst_dat", dat_a, 32'h0);
    chk("rst_fd", 32'(fd_a), 32'd0);
    chk("rst_sel", 32'(sel_a), 32'hF);
    chk("rst_cti", 32'(cti_a), 32'd0);
    chk("rst_bte", 32'(bte_a), 32'd0);
    chk("rst_adr_b", adr_b, 32'h1000);

    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_en", 32'(cyc_a), 32'd0);

    // Frame 1: ack tied high, bursts of 4 then 2 idle cycles.
    en_a  = 1'b1;
    ack_a = 1'b1;
    @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 4; i++) begin
        chk("f1_cyc", 32'(cyc_a), 32'd1);
        chk("f1_we", 32'(we_a), 32'd1);
        chk("f1_adr", adr_a, 32'((4 * b + i) * 4));
        chk("f1_dat", dat_a, exp_dat_a(4 * b + i));
        chk("f1_fd", 32'(fd_a), 32'd0);
        @(negedge clk);
      end
      for (int j = 0; j < 2; j++) begin
        chk("f1_pause_cyc", 32'(cyc_a), 32'd0);
        chk("f1_pause_fd", 32'(fd_a), (b == 7 && j == 0) ? 32'd1 : 32'd0);
        @(negedge clk);
      end
    end
    chk("f2_start_cyc", 32'(cyc_a), 32'd1);
    chk("f2_start_adr", adr_a, 32'h0);

    // Enable dropped after the 2nd ack: two more writes, pause, idle.
    @(negedge clk);
    chk("drop_adr4", adr_a, 32'd4);
    @(negedge clk);
    chk("drop_adr8", adr_a, 32'd8);
    en_a = 1'b0;
    @(negedge clk);
    chk("drop_adr12", adr_a, 32'd12);
    chk("drop_cyc12", 32'(cyc_a), 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("drop_idle_cyc", 32'(cyc_a), 32'd0);
    end
    // Stray acks in IDLE must not move the pixel position.
    repeat (3) begin
      @(negedge clk);
      chk("idle_ack_cyc", 32'(cyc_a), 32'd0);
      chk("idle_ack_adr", adr_a, 32'd16);
    end
    ack_a = 1'b0;
    en_a  = 1'b1;
    @(negedge clk);
    chk("resume_stb", 32'(stb_a), 32'd1);
    chk("resume_adr", adr_a, 32'd16);

    // Rest of frame 2 with ack delays of 0..5 cycles.
    for (int p = 4; p < 32; p++) begin
      wait_stb_a();
      for (int d = 0; d < (p % 6); d++) begin
        chk("slow_stb", 32'(stb_a), 32'd1);
        chk("slow_adr", adr_a, 32'(p * 4));
        chk("slow_dat", dat_a, exp_dat_a(p));
        @(negedge clk);
      end
      chk("slow_adr_ack", adr_a, 32'(p * 4));
      ack_a = 1'b1;
      @(negedge clk);
      ack_a = 1'b0;
      chk("slow_fd", 32'(fd_a), (p == 31) ? 32'd1 : 32'd0);
    end
    wait_stb_a();
    chk("f3_start_adr", adr_a, 32'h0);

    // Reset mid-write with ack low.
    ack_a = 1'b1;
    repeat (3) @(negedge clk);
    ack_a = 1'b0;
    chk("pre_rst_adr", adr_a, 32'd12);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_cyc", 32'(cyc_a), 32'd0);
    chk("mid_rst_stb", 32'(stb_a), 32'd0);
    chk("mid_rst_fd", 32'(fd_a), 32'd0);
    chk("mid_rst_adr", adr_a, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cyc", 32'(cyc_a), 32'd1);
    chk("post_rst_adr", adr_a, 32'h0);

    // Instance B: whole 20x10 frame, ack high, base 0x1000.
    en_b   = 1'b1;
    cnt_b  = 0;
    done_b = 1'b0;
    last_b = 32'h0;
    for (int n = 0; n < 1000 && !done_b; n++) begin
      @(negedge clk);
      if (fd_b === 1'b1) begin
        done_b = 1'b1;
      end else if (stb_b === 1'b1) begin
        chk("b_adr", adr_b, 32'h1000 + 32'(cnt_b * 4));
        chk("b_dat", dat_b, exp_dat_b(cnt_b));
        last_b = adr_b;
        cnt_b++;
      end
    end
    chk("b_frame_done_seen", 32'(done_b), 32'd1);
    chk("b_write_count", 32'(cnt_b), 32'd200);
    chk("b_last_adr", last_b, 32'h131C);
    chk("b_fd_cyc", 32'(cyc_b), 32'd0);
    @(negedge clk);
    chk("b_fd_one_cycle", 32'(fd_b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
